// File: rtl/shift_chain_controller.sv
// rtl/shift_chain_controller.sv - serializes a parallel word into the config shift chain, then pulses update.
// Optional readback of the previous chain contents is enabled by defining SHIFT_CTRL_READBACK_EN.
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module shift_chain_controller #(
   parameter int DATA_LEN   = `DATA_LEN,
   parameter int GAP_CYCLES = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [DATA_LEN-1:0] req_data,
   output logic                sr_data_in,
   output logic                sr_enable,
   output logic                sr_update,
   input  logic                sr_data_out,
   output logic                busy,
   output logic                done,
   output logic [DATA_LEN-1:0] rd_data,
   output logic                rd_valid
);

   typedef enum logic [1:0] {IDLE, SHIFT, SETTLE, UPDATE} state_t;

   localparam int CW = $clog2(DATA_LEN + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [DATA_LEN-1:0] data_q, data_d;
   logic                req_ready_q, req_ready_d;
   logic                sr_data_in_q, sr_data_in_d;
   logic                sr_enable_q, sr_enable_d;
   logic                sr_update_q, sr_update_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Outputs are registered, so each is computed for the state being entered.
   // data_q is consumed LSB first by shifting it right once per enable cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      gap_d        = gap_q;
      data_d       = data_q;
      req_ready_d  = 1'b0;
      sr_data_in_d = 1'b0;
      sr_enable_d  = 1'b0;
      sr_update_d  = 1'b0;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               state_d      = SHIFT;
               cnt_d        = '0;
               data_d       = {1'b0, req_data[DATA_LEN-1:1]};
               sr_enable_d  = 1'b1;
               sr_data_in_d = req_data[0];
            end else begin
               req_ready_d = 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q == CW'(DATA_LEN - 1)) begin
               gap_d = '0;
               if (GAP_CYCLES == 0) begin
                  state_d     = UPDATE;
                  sr_update_d = 1'b1;
                  done_d      = 1'b1;
               end else begin
                  state_d = SETTLE;
               end
            end else begin
               cnt_d        = cnt_q + CW'(1);
               sr_enable_d  = 1'b1;
               sr_data_in_d = data_q[0];
               data_d       = {1'b0, data_q[DATA_LEN-1:1]};
            end
         end
         SETTLE: begin
            if (gap_q == GAP_LAST) begin
               state_d     = UPDATE;
               sr_update_d = 1'b1;
               done_d      = 1'b1;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         gap_q        <= '0;
         data_q       <= '0;
         req_ready_q  <= 1'b0;
         sr_data_in_q <= 1'b0;
         sr_enable_q  <= 1'b0;
         sr_update_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         gap_q        <= gap_d;
         data_q       <= data_d;
         req_ready_q  <= req_ready_d;
         sr_data_in_q <= sr_data_in_d;
         sr_enable_q  <= sr_enable_d;
         sr_update_q  <= sr_update_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign sr_data_in = sr_data_in_q;
   assign sr_enable  = sr_enable_q;
   assign sr_update  = sr_update_q;
   assign busy       = busy_q;
   assign done       = done_q;

`ifdef SHIFT_CTRL_READBACK_EN
   logic [DATA_LEN-1:0] rd_data_q, rd_data_d;
   logic                rd_valid_q;

   // In shift cycle k the chain presents old cell k on sr_data_out; shifting in
   // from the top leaves that bit at position k after DATA_LEN samples.
   always_comb begin
      rd_data_d = rd_data_q;
      if (state_q == SHIFT) begin
         rd_data_d = {sr_data_out, rd_data_q[DATA_LEN-1:1]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= done_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`else
   logic unused_sr_data_out;
   assign unused_sr_data_out = sr_data_out;
   assign rd_data  = '0;
   assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_shift_chain_controller.sv
// tb/tb_shift_chain_controller.sv - scoreboard bench for shift_chain_controller (GAP_CYCLES=1 and 0 instances).
module tb_shift_chain_controller;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]   req_valid, req_ready, sr_data_in, sr_enable, sr_update, sr_data_out;
   logic [1:0]   busy, done, rd_valid;
   logic [N-1:0] req_data [2];
   logic [N-1:0] rd_data  [2];
   logic [N-1:0] cells    [2];
   logic [N-1:0] bit_out  [2];

   int checks = 0;
   int passed = 0;
   int viol   = 0;
   int cyc    = 0;

`ifdef SHIFT_CTRL_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   typedef struct packed {
      logic         inst;
      logic [N-1:0] word;
      logic [N-1:0] rd;
   } exp_t;
   exp_t exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
   endtask

   function automatic logic [N-1:0] rdx(input logic [N-1:0] w);
      return RB ? w : '0;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : u
      shift_chain_controller #(.DATA_LEN(N), .GAP_CYCLES((g == 0) ? 1 : 0)) dut (
         .clk(clk), .reset(rst),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_data(req_data[g]),
         .sr_data_in(sr_data_in[g]), .sr_enable(sr_enable[g]), .sr_update(sr_update[g]),
         .sr_data_out(sr_data_out[g]), .busy(busy[g]), .done(done[g]),
         .rd_data(rd_data[g]), .rd_valid(rd_valid[g])
      );

      // chain model: data enters at the top cell, data_out is cell 0
      always @(posedge clk or posedge rst) begin
         if (rst) begin
            cells[g]   <= '0;
            bit_out[g] <= '0;
         end else begin
            if (sr_enable[g]) cells[g] <= {sr_data_in[g], cells[g][N-1:1]};
            if (sr_update[g]) bit_out[g] <= cells[g];
         end
      end
      assign sr_data_out[g] = cells[g][0];

      logic [N-1:0] ser;
      logic [N-1:0] pend_word;
      int           en_cnt, gap_cnt;
      bit           pend;
      exp_t         e;

      always @(negedge clk) begin
         if (rst) begin
            ser = '0; en_cnt = 0; gap_cnt = 0; pend = 0;
         end else begin
            if (sr_enable[g] && sr_update[g]) viol++;
            if (sr_data_in[g] && !sr_enable[g]) viol++;
            if (done[g] != sr_update[g]) viol++;
            if (rd_valid[g] && !done[g]) viol++;
            if (pend) begin
               chk($sformatf("bit_out%0d", g), 32'(bit_out[g]), 32'(pend_word));
               pend = 0;
            end
            if (sr_enable[g]) begin
               ser = {sr_data_in[g], ser[N-1:1]};
               en_cnt++;
            end else if (busy[g] && !done[g] && en_cnt > 0) begin
               gap_cnt++;
            end
            if (done[g]) begin
               if (exp_q.size() == 0 || exp_q[0].inst != 1'(g)) begin
                  checks++;
                  $display("FAIL unexpected_done%0d: got done=1, expected no transfer", g);
               end else begin
                  e = exp_q.pop_front();
                  chk($sformatf("serial%0d", g), 32'(ser), 32'(e.word));
                  chk($sformatf("enable_cycles%0d", g), 32'(en_cnt), 32'(N));
                  chk($sformatf("gap%0d", g), 32'(gap_cnt), 32'((g == 0) ? 1 : 0));
                  chk($sformatf("rd_data%0d", g), 32'(rd_data[g]), 32'(e.rd));
                  chk($sformatf("rd_valid%0d", g), 32'(rd_valid[g]), 32'(RB));
                  pend = 1;
                  pend_word = e.word;
               end
               ser = '0; en_cnt = 0; gap_cnt = 0;
            end
         end
      end
   end

   task automatic wait_hs(input int g, output int c);
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[g] && req_valid[g]) ok = 1;
      end
      if (!ok) begin
         checks++;
         $display("FAIL hs_timeout%0d: got no handshake, expected one within 100 cycles", g);
      end
      c = cyc;
   endtask

   task automatic wait_idle(input int g);
      bit ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (!busy[g] && req_ready[g]) ok = 1;
      end
      if (!ok) begin
         checks++;
         $display("FAIL idle_timeout%0d: got busy, expected idle within 200 cycles", g);
      end
   endtask

   task automatic wait_done(input int g, input int c, output int lat);
      bit ok = 0;
      lat = -1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (done[g]) begin
            ok = 1;
            lat = cyc - c;
         end
      end
   endtask

   task automatic send(input int g, input logic [N-1:0] w, input logic [N-1:0] r, output int lat);
      exp_t e;
      int   c;
      e.inst = 1'(g); e.word = w; e.rd = r;
      exp_q.push_back(e);
      @(posedge clk); #1;
      req_valid[g] = 1'b1;
      req_data[g]  = w;
      wait_hs(g, c);
      @(posedge clk); #1;
      req_valid[g] = 1'b0;
      req_data[g]  = ~w;
      wait_done(g, c, lat);
      wait_idle(g);
   endtask

   initial begin
      int c1, c2, lat;
      req_valid = '0;
      req_data[0] = '0;
      req_data[1] = '0;
      #1 rst = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_outs", 32'({req_ready, busy, sr_enable, sr_update, done, sr_data_in, rd_valid}), 32'(0));
      chk("rst_rd_data", 32'(rd_data[0]), 32'(0));
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_before_edge", 32'(req_ready), 32'(0));
      @(negedge clk);
      chk("ready_after_edge", 32'(req_ready), 32'(2'b11));
      chk("busy_after_rst", 32'(busy), 32'(0));

      send(0, 8'hA5, rdx(8'h00), lat);
      chk("lat_gap1", 32'(lat), 32'(10));

      // back-to-back with req_valid held; req_data wiggles mid-shift
      begin
         exp_t e;
         e.inst = 1'b0; e.word = 8'h3C; e.rd = rdx(8'hA5); exp_q.push_back(e);
         e.inst = 1'b0; e.word = 8'hC3; e.rd = rdx(8'h3C); exp_q.push_back(e);
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_data[0]  = 8'h3C;
      wait_hs(0, c1);
      @(posedge clk); #1 req_data[0] = 8'hC3;
      repeat (3) @(posedge clk);
      #1 req_data[0] = 8'hFF;
      @(posedge clk); #1 req_data[0] = 8'hC3;
      wait_hs(0, c2);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      chk("b2b_spacing", 32'(c2 - c1), 32'(11));
      wait_idle(0);
      @(negedge clk);
      chk("b2b_final_bit_out", 32'(bit_out[0]), 32'(8'hC3));

      send(1, 8'hFF, rdx(8'h00), lat);
      chk("lat_gap0", 32'(lat), 32'(9));

      // abort after four shift cycles
      @(posedge clk); #1;
      req_valid[0] = 1'b1;
      req_data[0]  = 8'h96;
      wait_hs(0, c1);
      @(posedge clk); #1 req_valid[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_pre_enable", 32'(sr_enable[0]), 32'(1));
      rst = 1'b1;
      #1;
      chk("abort_outs", 32'({req_ready, busy, sr_enable, sr_update, done, sr_data_in}), 32'(0));
      chk("abort_chain_cleared", 32'(bit_out[0]), 32'(0));
      repeat (2) @(negedge clk);
      chk("abort_no_done", 32'({done, sr_update}), 32'(0));
      @(posedge clk); #1 rst = 1'b0;
      wait_idle(0);

      send(0, 8'h01, rdx(8'h00), lat);
      chk("lat_after_abort", 32'(lat), 32'(10));
      send(0, 8'h5A, rdx(8'h01), lat);
      send(0, 8'h0F, rdx(8'h5A), lat);

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'(0));
      chk("invariants", 32'(viol), 32'(0));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
